// File: rtl/comp_status_unit_pkg.sv
// Shared CRC/comparator definitions for the comparator status unit.
// Holds the task-key width, the register map, the EVENT word bit positions,
// the handshake state type and the event record carried through the FIFO.
package comp_status_unit_pkg;

  localparam int unsigned CRC_KEY_WIDTH = 4;
  localparam int unsigned CRC_KEY_SIZE  = 1 << CRC_KEY_WIDTH;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int unsigned EVT_VALID_BIT    = 31;
  localparam int unsigned EVT_MISMATCH_BIT = 4;
  localparam int unsigned EVT_TASK_LSB     = 0;
  localparam int unsigned EVT_WIDTH        = CRC_KEY_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ACK,
    ST_WAIT_LOW
  } hs_state_e;

  typedef struct packed {
    logic                     mismatch;
    logic [CRC_KEY_WIDTH-1:0] task_id;
  } event_t;

  // Formats a stored event as the EVENT register read word.
  function automatic logic [31:0] event_word(input event_t ev);
    logic [31:0] w;
    w = '0;
    w[EVT_VALID_BIT]                       = 1'b1;
    w[EVT_MISMATCH_BIT]                    = ev.mismatch;
    w[EVT_TASK_LSB +: CRC_KEY_WIDTH]       = ev.task_id;
    return w;
  endfunction

endpackage

// File: rtl/comp_event_fifo.sv
// Event FIFO for the comparator status unit.
// Show-ahead FIFO: head_data is the oldest entry whenever empty is low.
// Ports: clk/reset (sync, active high), push/push_data, pop, head_data,
//        full, empty, count (occupancy, log2(DEPTH)+1 bits).
// A push while full is accepted only when a pop happens in the same cycle.
module comp_event_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 5,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/comp_status_unit.sv
// Comparator status unit.
// Records pass/fail verdicts from the comparator via a 4-phase handshake,
// keeps sticky per-task pass/fail vectors, queues verdict events in a FIFO
// and exposes everything through a 4-word slave with a level interrupt.
// Ports: clk, reset (sync, active high);
//        comparator side: comp_status_write, comp_task, comp_mismatch_detected,
//                         comp_status_ack;
//        slave side: avs_address, avs_read, avs_write, avs_writedata,
//                    avs_readdata (registered), irq (registered).
module comp_status_unit
  import comp_status_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     comp_status_write,
  input  logic [CRC_KEY_WIDTH-1:0] comp_task,
  input  logic                     comp_mismatch_detected,
  output logic                     comp_status_ack,
  input  logic [1:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  hs_state_e               state_q, state_d;
  logic                    ack_q, ack_d;
  logic [CRC_KEY_SIZE-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [7:0]              ovf_q, ovf_d;
  logic                    irq_en_q, irq_en_d;
  logic                    irq_q, irq_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    capture;
  event_t                  ev_in;
  logic [EVT_WIDTH-1:0]    fifo_head;
  logic                    fifo_full, fifo_empty, fifo_pop, drop;
  logic [CNT_W-1:0]        fifo_count;
  logic [CRC_KEY_SIZE-1:0] set_vec, clr_pass, clr_fail;

  assign capture = (state_q == ST_CAPTURE);
  assign ev_in   = '{mismatch: comp_mismatch_detected, task_id: comp_task};

  assign fifo_pop = avs_read && (avs_address == ADDR_EVENT) && !fifo_empty;
  assign drop     = capture && fifo_full && !fifo_pop;

  comp_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (ev_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake: ack_d is raised on the way into ACK so the registered ack
  // is high for exactly the ACK cycle.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE:     if (comp_status_write) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
      end
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!comp_status_write) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    set_vec            = '0;
    set_vec[comp_task] = capture;
    clr_pass           = '0;
    clr_fail           = '0;
    if (avs_write && (avs_address == ADDR_STATUS)) begin
      clr_pass = avs_writedata[15:0];
      clr_fail = avs_writedata[31:16];
    end
    // Clear first, then set, so a same-cycle verdict survives the W1C.
    pass_d = (pass_q & ~clr_pass) | (comp_mismatch_detected ? '0 : set_vec);
    fail_d = (fail_q & ~clr_fail) | (comp_mismatch_detected ? set_vec : '0);

    ovf_d = (avs_write && (avs_address == ADDR_COUNT)) ? '0 : ovf_q;
    if (drop && (ovf_d != 8'hFF)) ovf_d = ovf_d + 8'd1;

    irq_en_d = irq_en_q;
    if (avs_write && (avs_address == ADDR_IRQ_EN)) irq_en_d = avs_writedata[0];

    irq_d = irq_en_q && (fifo_count != '0);

    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_STATUS: rdata_d = {fail_q, pass_q};
        ADDR_EVENT:  rdata_d = fifo_empty ? '0 : event_word(event_t'(fifo_head));
        ADDR_IRQ_EN: rdata_d = {31'b0, irq_en_q};
        ADDR_COUNT:  rdata_d = {16'h0, ovf_q, 2'b00, 6'(fifo_count)};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      ovf_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign comp_status_ack = ack_q;
  assign avs_readdata    = rdata_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_comp_status_unit.sv
module tb_comp_status_unit;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        comp_status_write = 1'b0;
  logic [3:0]  comp_task = '0;
  logic        comp_mismatch_detected = 1'b0;
  logic        comp_status_ack;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  always #5 clk = ~clk;

  comp_status_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .comp_status_write      (comp_status_write),
    .comp_task              (comp_task),
    .comp_mismatch_detected (comp_mismatch_detected),
    .comp_status_ack        (comp_status_ack),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_readdata           (avs_readdata),
    .irq                    (irq)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: verdict bit sets, an event queue and counters.
  bit [15:0]   m_pass, m_fail;
  logic [31:0] m_q[$];
  int          m_ovf;
  bit          m_irq_en;

  typedef enum {OP_REQ, OP_RD, OP_WR} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pass = '0; m_fail = '0; m_q.delete(); m_ovf = 0; m_irq_en = 0;
  endtask

  task automatic model_req(input int t, input bit mm);
    if (m_q.size() < DEPTH) m_q.push_back(32'h8000_0000 | (32'(mm) << 4) | 32'(t));
    else if (m_ovf < 255) m_ovf++;
    if (mm) m_fail[t] = 1'b1; else m_pass[t] = 1'b1;
  endtask

  task automatic model_read(input logic [1:0] a, output logic [31:0] v);
    case (a)
      2'd0: v = {m_fail, m_pass};
      2'd1: v = (m_q.size() != 0) ? m_q.pop_front() : 32'h0;
      2'd2: v = {31'b0, m_irq_en};
      default: v = (32'(m_ovf) << 8) | 32'(m_q.size());
    endcase
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: begin m_pass &= ~d[15:0]; m_fail &= ~d[31:16]; end
      2'd2: m_irq_en = d[0];
      2'd3: m_ovf = 0;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; comp_status_write = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic request(input int t, input bit mm);
    comp_status_write = 1'b1; comp_task = t[3:0]; comp_mismatch_detected = mm;
    tick(); check("ack_early", 32'(comp_status_ack), 0);
    tick(); check("ack_lat2", 32'(comp_status_ack), 1);
    tick(); check("ack_width", 32'(comp_status_ack), 0);
    comp_status_write = 1'b0;
    tick();
    model_req(t, mm);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    avs_read = 1'b1; avs_address = a;
    tick();
    v = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0;
    model_write(a, d);
  endtask

  // Read a register and compare against a hand-computed constant; the model
  // is advanced too so it stays in step.
  task automatic rd_const(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v, m;
    rd(a, v);
    model_read(a, m);
    check(name, v, exp);
  endtask

  task automatic rd_model(input logic [1:0] a, input string name);
    logic [31:0] v, m;
    rd(a, v);
    model_read(a, m);
    check(name, v, m);
  endtask

  initial begin
    int acks;
    logic [31:0] v;

    // ---------------- table-driven vectors ----------------
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_RD,  2'd1, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_RD,  2'd2, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_RD,  2'd3, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_REQ, 2'd0, 32'h05, 32'h0});
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h0000_0020});
    vecs.push_back('{OP_RD,  2'd3, 32'h0, 32'h0000_0001});
    vecs.push_back('{OP_RD,  2'd1, 32'h0, 32'h8000_0005});
    vecs.push_back('{OP_RD,  2'd3, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_RD,  2'd1, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_WR,  2'd0, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h0000_0000});
    vecs.push_back('{OP_WR,  2'd2, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{OP_RD,  2'd2, 32'h0, 32'h0000_0001});
    vecs.push_back('{OP_REQ, 2'd0, 32'h1C, 32'h0});
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h1000_0000});
    vecs.push_back('{OP_RD,  2'd1, 32'h0, 32'h8000_001C});
    vecs.push_back('{OP_REQ, 2'd0, 32'h0F, 32'h0});
    vecs.push_back('{OP_REQ, 2'd0, 32'h1F, 32'h0});
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h9000_8000});
    vecs.push_back('{OP_RD,  2'd3, 32'h0, 32'h0000_0002});
    vecs.push_back('{OP_WR,  2'd0, 32'h0000_8000, 32'h0});
    vecs.push_back('{OP_RD,  2'd0, 32'h0, 32'h9000_0000});
    vecs.push_back('{OP_WR,  2'd2, 32'h0, 32'h0});
    vecs.push_back('{OP_RD,  2'd2, 32'h0, 32'h0000_0000});

    do_reset();
    check("rst_ack", 32'(comp_status_ack), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", avs_readdata, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_REQ: request(int'(vecs[i].data[3:0]), vecs[i].data[4]);
        OP_WR:  wr(vecs[i].addr, vecs[i].data);
        default: rd_const(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      endcase
    end

    // ---------------- irq follows occupancy ----------------
    do_reset();
    wr(2'd2, 32'h1);
    request(12, 1'b1);
    check("irq_set", 32'(irq), 1);
    rd_const(2'd1, 32'h8000_001C, "irq_evt");
    check("irq_hold", 32'(irq), 1);
    tick();
    check("irq_fall", 32'(irq), 0);
    check("rdata_idle", avs_readdata, 0);

    // ---------------- overflow ----------------
    do_reset();
    for (int t = 0; t < 9; t++) request(t, 1'b0);
    rd_const(2'd3, 32'h0000_0108, "ovf_count");
    for (int t = 0; t < 8; t++) rd_const(2'd1, 32'h8000_0000 | 32'(t), $sformatf("ovf_evt%0d", t));
    rd_const(2'd1, 32'h0, "ovf_empty");
    rd_const(2'd0, 32'h0000_01FF, "ovf_status");
    wr(2'd3, 32'h0);
    rd_const(2'd3, 32'h0, "ovf_clear");

    // ---------------- full FIFO, pop in the capture cycle ----------------
    do_reset();
    for (int t = 0; t < 8; t++) request(t, 1'b0);
    comp_status_write = 1'b1; comp_task = 4'd9; comp_mismatch_detected = 1'b1;
    tick();
    avs_read = 1'b1; avs_address = 2'd1;
    tick();
    check("fullpop_evt", avs_readdata, 32'h8000_0000);
    check("fullpop_ack", 32'(comp_status_ack), 1);
    avs_read = 1'b0;
    tick();
    comp_status_write = 1'b0;
    tick();
    model_read(2'd1, v);
    model_req(9, 1'b1);
    rd_const(2'd3, 32'h0000_0008, "fullpop_count");
    for (int t = 1; t < 8; t++) rd_const(2'd1, 32'h8000_0000 | 32'(t), $sformatf("fullpop_evt%0d", t));
    rd_const(2'd1, 32'h8000_0019, "fullpop_new");

    // ---------------- W1C colliding with a set ----------------
    do_reset();
    comp_status_write = 1'b1; comp_task = 4'd5; comp_mismatch_detected = 1'b0;
    tick();
    avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'h20;
    tick();
    avs_write = 1'b0;
    tick();
    comp_status_write = 1'b0;
    tick();
    model_write(2'd0, 32'h20);
    model_req(5, 1'b0);
    rd_const(2'd0, 32'h0000_0020, "w1c_setwins");
    wr(2'd0, 32'h20);
    rd_const(2'd0, 32'h0, "w1c_clear");

    // ---------------- held request, resets mid-handshake ----------------
    do_reset();
    comp_status_write = 1'b1; comp_task = 4'd2; comp_mismatch_detected = 1'b0;
    acks = 0;
    repeat (6) begin tick(); if (comp_status_ack) acks++; end
    comp_status_write = 1'b0;
    repeat (3) begin tick(); if (comp_status_ack) acks++; end
    check("hold_acks", 32'(acks), 1);
    rd_const(2'd3, 32'h1, "hold_count");
    rd_const(2'd1, 32'h8000_0002, "hold_evt");

    comp_status_write = 1'b1; comp_task = 4'd3;
    tick();
    reset = 1'b1;
    tick();
    check("rstcap_ack", 32'(comp_status_ack), 0);
    reset = 1'b0;
    model_clear();
    tick();
    check("rstcap_ack2", 32'(comp_status_ack), 0);
    tick();
    check("rstcap_newack", 32'(comp_status_ack), 1);
    tick();
    comp_status_write = 1'b0;
    tick();
    model_req(3, 1'b0);
    rd_const(2'd0, 32'h0000_0008, "rstcap_status");
    rd_const(2'd3, 32'h1, "rstcap_count");

    wr(2'd2, 32'h1);
    comp_status_write = 1'b1; comp_task = 4'd4; comp_mismatch_detected = 1'b1;
    tick();
    tick();
    check("rstack_pre", 32'(comp_status_ack), 1);
    reset = 1'b1; comp_status_write = 1'b0;
    tick();
    check("rstack_ack", 32'(comp_status_ack), 0);
    check("rstack_irq", 32'(irq), 0);
    reset = 1'b0;
    model_clear();
    rd_const(2'd0, 32'h0, "rstack_status");
    rd_const(2'd3, 32'h0, "rstack_count");
    rd_const(2'd2, 32'h0, "rstack_irqen");

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        request($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end else if (r <= 5) begin
        rd_model(2'd1, "rnd_evt");
      end else if (r <= 7) begin
        rd_model(2'($urandom_range(0, 3)), "rnd_rd");
      end else begin
        wr(2'($urandom_range(0, 3)), $urandom);
      end
      tick();
      check("rnd_irq", 32'(irq), 32'(m_irq_en && (m_q.size() != 0)));
      check("rnd_rdata_idle", avs_readdata, 0);
    end
    rd_model(2'd3, "rnd_count_end");
    rd_model(2'd0, "rnd_status_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
